// File: rtl/cgra_config_loader.sv
// cgra_config_loader: assembles configuration words into the CGRA bitstream, commits it and sequences execute
module cgra_config_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int BITSTREAM_WIDTH = 160
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [DATA_WIDTH-1:0]      cfg_word_i,
  input  logic                       cfg_word_valid_i,
  output logic                       cfg_word_ready_o,
  input  logic                       exec_start_i,
  input  logic                       exec_stop_i,
  output logic [BITSTREAM_WIDTH-1:0] config_bitstream_o,
  output logic                       bitstream_enable_o,
  output logic                       execute_o,
  output logic                       configured_o,
  output logic                       done_o
);
  localparam int NUM_WORDS = (BITSTREAM_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PAD_W     = NUM_WORDS * DATA_WIDTH;
  localparam int CNT_W     = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int OFF_W     = PAD_W > 1 ? $clog2(PAD_W) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMMIT, S_ARMED, S_RUN} state_t;
  state_t                     r_state, w_next_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [BITSTREAM_WIDTH-1:0] r_bits;
  logic                       r_configured, r_done;
  logic                       w_xfer, w_last, w_load_start;
  logic [OFF_W-1:0]           w_off;
  logic [PAD_W-1:0]           w_pad;
  assign w_xfer       = r_state == S_LOAD && cfg_word_valid_i;
  assign w_last       = r_cnt == CNT_W'(NUM_WORDS - 1);
  assign w_load_start = (r_state == S_IDLE || r_state == S_ARMED) && load_i;
  assign w_off        = OFF_W'(r_cnt) * OFF_W'(DATA_WIDTH);
  // Merge the incoming word into a word-aligned copy of the bitstream; the overhang of a partial last word is truncated on store
  always_comb begin
    w_pad = PAD_W'(r_bits);
    w_pad[w_off +: DATA_WIDTH] = cfg_word_i;
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end
  // Next-state logic; load_i wins over exec_start_i in ARMED
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = load_i ? S_LOAD : S_IDLE;
      S_LOAD:   w_next_state = (w_xfer && w_last) ? S_COMMIT : S_LOAD;
      S_COMMIT: w_next_state = S_ARMED;
      S_ARMED:  w_next_state = load_i ? S_LOAD : (exec_start_i ? S_RUN : S_ARMED);
      S_RUN:    w_next_state = exec_stop_i ? S_ARMED : S_RUN;
      default:  w_next_state = S_IDLE;
    endcase
  end
  // Word counter, bitstream storage, configured flag and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bits       <= '0;
      r_configured <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= r_state == S_RUN && exec_stop_i;
      if (w_load_start) begin
        r_cnt        <= '0;
        r_configured <= 1'b0;
      end else if (w_xfer) begin
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        r_bits <= w_pad[BITSTREAM_WIDTH-1:0];
      end
      if (r_state == S_COMMIT) r_configured <= 1'b1;
    end
  end
  // Outputs decoded from state, so enable and execute can never overlap
  always_comb begin
    cfg_word_ready_o   = r_state == S_LOAD;
    bitstream_enable_o = r_state == S_COMMIT;
    execute_o          = r_state == S_RUN;
    configured_o       = r_configured;
    done_o             = r_done;
    config_bitstream_o = r_bits;
  end
endmodule
